ctrl_seq: RTL

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/ctrl_seq_if.sv | 44 ++++
 rtl/ctrl_seq.sv | 123 ++++++++++++
 2 files changed

// File: rtl/ctrl_seq_if.sv
// Sequencer <-> datapath bundle: master is the sequencer, slave the ROM/ALU/regfile side.
// The stall signal exists only when CTRL_SEQ_STALL_EN is defined.
interface ctrl_seq_if #(
    parameter int IW = 9,
    parameter int RW = 3
);
  logic          start;
  logic [IW-1:0] instruction;
  logic          zero;
`ifdef CTRL_SEQ_STALL_EN
  logic          stall;
`endif
  logic          pc_en;
  logic          jump_taken;
  logic          reg_wr_en;
  logic          mem_wr_en;
  logic          load_inst;
  logic          store_inst;
  logic [1:0]    write_source;
  logic [RW-1:0] read_reg_addr;
  logic [RW-1:0] write_reg_addr;
  logic [2:0]    alu_op;
  logic          busy;
  logic          ack;
  logic [15:0]   inst_count;

  modport master (
`ifdef CTRL_SEQ_STALL_EN
    input  stall,
`endif
    input  start, instruction, zero,
    output pc_en, jump_taken, reg_wr_en, mem_wr_en, load_inst, store_inst,
    output write_source, read_reg_addr, write_reg_addr, alu_op, busy, ack, inst_count
  );

  modport slave (
`ifdef CTRL_SEQ_STALL_EN
    output stall,
`endif
    output start, instruction, zero,
    input  pc_en, jump_taken, reg_wr_en, mem_wr_en, load_inst, store_inst,
    input  write_source, read_reg_addr, write_reg_addr, alu_op, busy, ack, inst_count
  );
endinterface

// File: rtl/ctrl_seq.sv
// Control sequencer: combinational decode per cycle, loads wait MEM_LAT cycles in MEMWAIT.
// No backpressure except optional CTRL_SEQ_STALL_EN stall, which freezes EXEC side effects.
module ctrl_seq #(
    parameter int IW      = 9,
    parameter int RW      = 3,
    parameter int MEM_LAT = 2
) (
  input logic      clk,
  input logic      rst,
  ctrl_seq_if.master bus
);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  localparam logic [2:0] ALU_LSH = 3'b000;
  localparam logic [2:0] ALU_RSH = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_CMP = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, MEMWAIT, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] wait_cnt;
  logic [15:0]   inst_count;
  logic          halt_retire;
  logic          stall;

  logic [2:0]    op;
  logic [RW-1:0] rd, rs;
  logic          halt;

  assign op   = bus.instruction[IW-1 -: 3];
  assign rd   = bus.instruction[IW-4 -: RW];
  assign rs   = bus.instruction[IW-4-RW -: RW];
  assign halt = &bus.instruction;

`ifdef CTRL_SEQ_STALL_EN
  assign stall = bus.stall;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      inst_count <= '0;
    end else begin
      state      <= state_n;
      wait_cnt   <= (state == MEMWAIT && wait_cnt != LAST) ? wait_cnt + 1'b1 : '0;
      if (bus.pc_en || halt_retire)
        inst_count <= inst_count + 16'd1;
    end
  end

  always_comb begin
    state_n            = state;
    halt_retire        = 1'b0;
    bus.pc_en          = 1'b0;
    bus.jump_taken     = 1'b0;
    bus.reg_wr_en      = 1'b0;
    bus.mem_wr_en      = 1'b0;
    bus.load_inst      = 1'b0;
    bus.store_inst     = 1'b0;
    bus.write_source   = 2'b00;
    bus.read_reg_addr  = '0;
    bus.write_reg_addr = '0;
    bus.alu_op         = 3'b000;
    case (state)
      IDLE: if (bus.start) state_n = EXEC;
      EXEC: begin
        bus.write_reg_addr = rd;
        bus.read_reg_addr  = rs;
        if (halt) begin
          halt_retire = 1'b1;
          state_n     = DONE;
        end else begin
          case (op)
            3'b000: begin bus.reg_wr_en = 1'b1; bus.alu_op = ALU_LSH; bus.pc_en = 1'b1; end
            3'b001: begin bus.reg_wr_en = 1'b1; bus.alu_op = ALU_RSH; bus.pc_en = 1'b1; end
            3'b010: begin bus.reg_wr_en = 1'b1; bus.alu_op = ALU_ADD; bus.pc_en = 1'b1; end
            3'b011: begin bus.load_inst = 1'b1; state_n = MEMWAIT; end
            3'b100: begin bus.mem_wr_en = 1'b1; bus.store_inst = 1'b1; bus.pc_en = 1'b1; end
            3'b101: begin bus.reg_wr_en = 1'b1; bus.write_source = 2'b10; bus.pc_en = 1'b1; end
            3'b110: begin
              // rd MSB picks jne (1) or je (0)
              bus.alu_op     = ALU_CMP;
              bus.pc_en      = 1'b1;
              bus.jump_taken = rd[RW-1] ? ~bus.zero : bus.zero;
            end
            default: begin bus.reg_wr_en = 1'b1; bus.write_source = 2'b11; bus.pc_en = 1'b1; end
          endcase
        end
        if (stall) begin
          bus.pc_en      = 1'b0;
          bus.reg_wr_en  = 1'b0;
          bus.mem_wr_en  = 1'b0;
          bus.store_inst = 1'b0;
          bus.jump_taken = 1'b0;
          halt_retire    = 1'b0;
          state_n        = EXEC;
        end
      end
      MEMWAIT: begin
        bus.load_inst      = 1'b1;
        bus.write_source   = 2'b01;
        bus.write_reg_addr = rd;
        bus.read_reg_addr  = rs;
        if (wait_cnt == LAST) begin
          bus.reg_wr_en = 1'b1;
          bus.pc_en     = 1'b1;
          state_n       = EXEC;
        end
      end
      DONE: if (bus.start) state_n = EXEC;
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy       = (state == EXEC) || (state == MEMWAIT);
  assign bus.ack        = (state == DONE);
  assign bus.inst_count = inst_count;
endmodule
